branch_predict_ctrl: RTL

Controller that sequences the one-bit branch predictor table in the RISC-V pipeline. It owns the table write port, clears every entry after reset or on request, and resolves each branch reaching EX/MEM against its prediction. On a misprediction it drives the fetch redirect and the pipeline flushes, and it keeps branch and mispredict statistics. It sits between the EX/MEM pipeline register, the predictor table, the PC-select mux and the hazard unit.

---
 rtl/branch_predict_ctrl.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/branch_predict_ctrl.sv
// Branch predictor table sequencer: clears the table, resolves EX/MEM
// branches, drives fetch redirect and pipeline flushes, keeps statistics.
module branch_predict_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int BRANCH_NO  = 8,
    parameter int IDX_W      = $clog2(BRANCH_NO),
    parameter int CNT_W      = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  bp_clear_req,
    input  logic                  ex_mem_valid,
    input  logic [6:0]            ex_mem_opcode,
    input  logic [DATA_WIDTH-1:0] ex_mem_pc,
    input  logic                  ex_mem_pred_taken,
    input  logic [DATA_WIDTH-1:0] ex_mem_pred_target,
    input  logic                  ex_mem_branch_taken,
    input  logic [DATA_WIDTH-1:0] ex_mem_branch_target,
    output logic                  bp_wr_en,
    output logic [IDX_W-1:0]      bp_wr_idx,
    output logic                  bp_wr_taken,
    output logic [DATA_WIDTH-1:0] bp_wr_target,
    output logic                  redirect_valid,
    output logic [DATA_WIDTH-1:0] redirect_pc,
    output logic                  flush_if_id,
    output logic                  flush_id_ex,
    output logic                  flush_ex_mem,
    output logic                  stall_fetch,
    output logic                  busy_clear,
    output logic [CNT_W-1:0]      branch_cnt,
    output logic [CNT_W-1:0]      mispredict_cnt
);

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BRANCH_NO - 1);

    typedef enum logic [1:0] {
        CLEAR   = 2'd0,
        RUN     = 2'd1,
        RECOVER = 2'd2
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] clr_idx;
    logic             clr_pend;

    logic in_clear;
    logic resolve;
    logic dir_miss;
    logic tgt_miss;
    logic mispred;

    always_comb begin
        in_clear = (state == CLEAR) && i_rst_n;
        resolve  = (state == RUN) && ex_mem_valid
                   && (ex_mem_opcode == OP_BRANCH);
        dir_miss = ex_mem_pred_taken != ex_mem_branch_taken;
        tgt_miss = ex_mem_pred_taken && ex_mem_branch_taken
                   && (ex_mem_pred_target != ex_mem_branch_target);
        mispred  = resolve && (dir_miss || tgt_miss);
    end

    // Write port: sweep during clear, resolved outcome during run.
    always_comb begin
        bp_wr_en     = 1'b0;
        bp_wr_idx    = '0;
        bp_wr_taken  = 1'b0;
        bp_wr_target = '0;
        unique case (1'b1)
            in_clear: begin
                bp_wr_en  = 1'b1;
                bp_wr_idx = clr_idx;
            end
            resolve: begin
                bp_wr_en     = 1'b1;
                bp_wr_idx    = ex_mem_pc[IDX_W+1:2];
                bp_wr_taken  = ex_mem_branch_taken;
                bp_wr_target = ex_mem_branch_target;
            end
            default: ;
        endcase
    end

    always_comb begin
        redirect_valid = mispred;
        redirect_pc    = '0;
        if (mispred) begin
            redirect_pc = ex_mem_branch_taken ? ex_mem_branch_target
                        : ex_mem_pc + DATA_WIDTH'(4);
        end
        flush_if_id  = mispred;
        flush_id_ex  = mispred;
        flush_ex_mem = mispred;
        stall_fetch  = state == CLEAR;
        busy_clear   = state == CLEAR;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state          <= CLEAR;
            clr_idx        <= '0;
            clr_pend       <= 1'b0;
            branch_cnt     <= '0;
            mispredict_cnt <= '0;
        end else begin
            unique case (state)
                CLEAR: begin
                    clr_idx <= clr_idx + 1'b1;
                    if (clr_idx == LAST_IDX) begin
                        clr_idx <= '0;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    if (resolve && branch_cnt != '1)
                        branch_cnt <= branch_cnt + 1'b1;
                    if (mispred && mispredict_cnt != '1)
                        mispredict_cnt <= mispredict_cnt + 1'b1;
                    if (mispred) begin
                        state <= RECOVER;
                        if (bp_clear_req) clr_pend <= 1'b1;
                    end else if (bp_clear_req) begin
                        state   <= CLEAR;
                        clr_idx <= '0;
                    end
                end
                RECOVER: begin
                    // A request arriving during recovery counts as pending.
                    if (clr_pend || bp_clear_req) begin
                        state    <= CLEAR;
                        clr_idx  <= '0;
                        clr_pend <= 1'b0;
                    end else begin
                        state <= RUN;
                    end
                end
                default: state <= CLEAR;
            endcase
        end
    end

endmodule
